// File: rtl/decoder_scan.sv
// Registered N-to-2^N one-hot decoder with a self-timed sweep that walks one hot bit across all outputs.
// Define DECODER_SCAN_ONEHOT_CHECK_EN to build the sticky one-hot checker that drives err.
module decoder_scan #(
  parameter int N = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N-1:0]     sel,
  input  logic             en,
  input  logic             clear_req,
  output logic [2**N-1:0]  o,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int unsigned W = 2**N;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

  state_t         r_state;
  logic [N-1:0]   r_cnt;
  logic [W-1:0]   r_o;
  logic           r_busy;
  logic           r_done;

  logic [W-1:0]   w_dec;
  logic [W-1:0]   w_scan;

  assign w_dec  = en ? (W'(1) << sel) : '0;
  assign w_scan = W'(1) << r_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_o     <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (clear_req) begin
            r_state <= SCAN;
            r_cnt   <= N'(1);
            r_o     <= W'(1);
            r_busy  <= 1'b1;
          end else begin
            r_o <= w_dec;
          end
        end
        SCAN: begin
          // r_cnt has already wrapped to zero when the top bit is showing, so the exit leaves it cleared
          if (r_o[W-1]) begin
            r_state <= DONE;
            r_o     <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_o   <= w_scan;
            r_cnt <= r_cnt + N'(1);
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_o     <= w_dec;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
          r_o     <= '0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign o    = r_o;
  assign busy = r_busy;
  assign done = r_done;

`ifdef DECODER_SCAN_ONEHOT_CHECK_EN
  logic r_err;
  logic w_multi;
  logic w_done_nz;

  // x & (x-1) clears the lowest set bit; anything left means two or more bits were set
  assign w_multi   = |(r_o & (r_o - W'(1)));
  assign w_done_nz = (r_state == DONE) && (|r_o);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_err <= 1'b0;
    end else if (w_multi || w_done_nz) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_decoder_scan.sv
// Bench for decoder_scan at N=2 and N=5, checked against a sweep-offset reference model.
module tb_decoder_scan;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rstn = 1'b1, a_en = 1'b0, a_clr = 1'b0;
  logic [1:0]  a_sel = '0;
  logic [3:0]  a_o;
  logic        a_busy, a_done, a_err;

  logic        b_rstn = 1'b1, b_en = 1'b0, b_clr = 1'b0;
  logic [4:0]  b_sel = '0;
  logic [31:0] b_o;
  logic        b_busy, b_done, b_err;

  decoder_scan #(.N(2)) dut_a (
    .clk(clk), .reset_n(a_rstn), .sel(a_sel), .en(a_en), .clear_req(a_clr),
    .o(a_o), .busy(a_busy), .done(a_done), .err(a_err)
  );

  decoder_scan #(.N(5)) dut_b (
    .clk(clk), .reset_n(b_rstn), .sel(b_sel), .en(b_en), .clear_req(b_clr),
    .o(b_o), .busy(b_busy), .done(b_done), .err(b_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model: mk = cycles since the sweep request (-1 when idle); 0..size-1 show that bit, size is the done cycle.
  int          mk  [2] = '{-1, -1};
  int          msz [2] = '{4, 32};
  logic [63:0] mo  [2] = '{64'd0, 64'd0};

  function automatic logic [63:0] exp_busy(int i);
    return 64'((mk[i] >= 0) && (mk[i] < msz[i]));
  endfunction

  function automatic logic [63:0] exp_done(int i);
    return 64'(mk[i] == msz[i]);
  endfunction

  task automatic model_edge(int i, int s, logic e, logic c, logic r);
    if (!r) begin
      mk[i] = -1;
      mo[i] = 64'd0;
    end else begin
      if (mk[i] == -1) begin
        if (c) mk[i] = 0;
        else   mo[i] = e ? (64'd1 << s) : 64'd0;
      end else if (mk[i] < msz[i]) begin
        mk[i] = mk[i] + 1;
      end else begin
        mk[i] = -1;
        mo[i] = e ? (64'd1 << s) : 64'd0;
      end
      if (mk[i] >= 0) mo[i] = (mk[i] < msz[i]) ? (64'd1 << mk[i]) : 64'd0;
    end
  endtask

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] want);
    n_cmp++;
    assert (obs === want) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic check_all();
    chk("a_o",    64'(a_o),    mo[0]);
    chk("a_busy", 64'(a_busy), exp_busy(0));
    chk("a_done", 64'(a_done), exp_done(0));
    chk("a_err",  64'(a_err),  64'd0);
    chk("b_o",    64'(b_o),    mo[1]);
    chk("b_busy", 64'(b_busy), exp_busy(1));
    chk("b_done", 64'(b_done), exp_done(1));
    chk("b_err",  64'(b_err),  64'd0);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge(0, int'(a_sel), a_en, a_clr, a_rstn);
    model_edge(1, int'(b_sel), b_en, b_clr, b_rstn);
    #1;
    check_all();
  endtask

  initial begin
    // asynchronous reset, observed before any clock edge
    #2;
    a_rstn = 1'b0;
    b_rstn = 1'b0;
    #1;
    mk[0] = -1; mk[1] = -1; mo[0] = 64'd0; mo[1] = 64'd0;
    check_all();
    repeat (2) cycle();
    a_rstn = 1'b1;
    b_rstn = 1'b1;

    // normal decode, N=2
    a_en = 1'b0;
    cycle();
    for (int s = 0; s < 4; s++) begin
      a_en  = 1'b1;
      a_sel = 2'(s);
      cycle();
    end
    a_en = 1'b0;
    cycle();

    // sweep request with a competing decode; then junk inputs while busy
    a_clr = 1'b1; a_en = 1'b1; a_sel = 2'd3;
    cycle();
    chk("a_prio_first", 64'(a_o), 64'd1);
    repeat (5) begin
      a_en  = 1'($urandom);
      a_sel = 2'($urandom);
      a_clr = 1'($urandom);
      cycle();
    end
    a_clr = 1'b0; a_en = 1'b0;
    repeat (2) cycle();

    // full N=5 sweep
    b_clr = 1'b1;
    cycle();
    b_clr = 1'b0;
    repeat (34) begin
      b_en  = 1'($urandom);
      b_sel = 5'($urandom);
      cycle();
    end

    // reset while the sweep shows bit 7
    b_en = 1'b0;
    b_clr = 1'b1;
    cycle();
    b_clr = 1'b0;
    repeat (7) cycle();
    chk("b_o_bit7", 64'(b_o), 64'd1 << 7);
    b_rstn = 1'b0;
    #1;
    mk[1] = -1;
    mo[1] = 64'd0;
    check_all();
    b_en = 1'b1; b_sel = 5'd9; b_rstn = 1'b1;
    cycle();
    chk("b_after_rst", 64'(b_o), 64'd1 << 9);

    // random traffic on both instances
    repeat (400) begin
      a_en  = 1'($urandom);
      a_sel = 2'($urandom);
      a_clr = ($urandom_range(7) == 0);
      b_en  = 1'($urandom);
      b_sel = 5'($urandom);
      b_clr = ($urandom_range(15) == 0);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/decoder_scan.md
# decoder_scan

Parametrised registered N-to-2^N one-hot decoder with a built-in sequential sweep mode. In normal mode it registers a one-hot decode of `sel` gated by `en`. On request it walks a single hot bit across every output, one per cycle, and then signals completion. It sits in front of the register file as the write-enable select. The sweep mode is used to clear or initialise every register after reset without an external address counter.

## Interface
Parameters:
- `N`, default 5: select width; output width is 2^N (default 32).

Ports:
- `clk` input 1: clock; all state changes on the rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `sel` input N: decode index, normal mode.
- `en` input 1: decode enable, normal mode.
- `clear_req` input 1: start sweep; sampled only in IDLE.
- `o` output 2^N: registered one-hot (or all-zero) output.
- `busy` output 1: high during SCAN.
- `done` output 1: one-cycle pulse after the last sweep index.
- `err` output 1: sticky one-hot violation flag (see Configuration).

## Operation
- States: IDLE, SCAN, DONE. Internal counter `cnt` is N bits wide.
- IDLE:
  - `o` <= `en` ? (1 << `sel`) : 0.
  - If `clear_req`=1: go to SCAN, `cnt` <= 1, `o` <= 1 (bit 0).
  - `clear_req` has priority over `en`/`sel` in the same cycle.
- SCAN:
  - `o` <= 1 << `cnt`, and `cnt` increments.
  - When `o` holds bit 2^N-1: go to DONE, `o` <= 0.
  - `en`, `sel` and `clear_req` are ignored; no request is queued.
  - `cnt` wraps naturally at 2^N. The wrap coincides with the exit to DONE, so there is no second pass.
- DONE:
  - `done`=1, `o`=0 for exactly one cycle, then IDLE.
  - `clear_req` in DONE is ignored.
- `busy` = (state == SCAN). `done` = (state == DONE). Both are registered-state decodes and glitch-free.
- Reset (`reset_n`=0, at any time including mid-SCAN):
  - Immediately: `o`=0, `busy`=0, `done`=0, `err`=0, state IDLE, `cnt`=0.
  - The sweep is abandoned, not resumed.
- First edge after reset deassertion behaves as IDLE.

## Timing
- Normal-mode latency: 1 cycle. `sel`/`en` sampled at edge k appear on `o` after edge k.
- `o` is never combinational from inputs.
- Sweep, with `clear_req` sampled at edge t:
  - After edge t: `o`=bit 0, `busy`=1.
  - After edge t+i: `o`=bit i, for i = 0..2^N-1.
  - After edge t+2^N: `o`=0, `busy`=0, `done`=1.
  - After edge t+2^N+1: IDLE decode of the inputs sampled at that edge.
- Total sweep occupancy: 2^N+1 cycles from request to the first usable normal decode.
- `o` always has at most one bit set, in every state and cycle.

## Configuration
- `DECODER_SCAN_ONEHOT_CHECK_EN` defined:
  - A checker compares the registered `o` each cycle. It asserts `err` (sticky until `reset_n`) if more than one bit is set.
  - It also asserts `err` if `o` is nonzero while in DONE.
- Not defined: `err` is tied to 0 and no checker logic is synthesised. All other behaviour is identical.

## Test plan
- Normal decode, N=2:
  - `en`=0 → `o`=0000.
  - `en`=1, `sel`=0,1,2,3 → `o`=0001, 0010, 0100, 1000, each one cycle after the input.
  - `en`=0 at the end → `o`=0000 next cycle.
- Sweep, N=2: pulse `clear_req` in IDLE.
  - `o` = 0001, 0010, 0100, 1000 on successive cycles with `busy`=1.
  - Then `o`=0000 with `done`=1 for one cycle, then IDLE.
- Priority and ignore, N=2:
  - `clear_req`=1 with `en`=1, `sel`=3 → first output 0001 (sweep wins).
  - `en`/`sel`/`clear_req` toggled mid-SCAN → sequence unchanged, no second sweep.
- Reset mid-sweep, N=5:
  - Assert `reset_n`=0 asynchronously while `o`=bit 7 → `o`=0, `busy`=0 without waiting for a clock edge.
  - After release with `en`=1, `sel`=9 → `o`=bit 9 after one edge.
- Default N=5 full sweep:
  - Exactly 32 consecutive one-hot values 2^0..2^31, then `done` on cycle 33.
  - `err` remains 0 throughout (with `DECODER_SCAN_ONEHOT_CHECK_EN` defined).
- Macro off:
  - Same regression without the macro → identical `o`/`busy`/`done` traces, `err` constantly 0.
